// File: rtl/adc_uart_pkg.sv
// Shared types and constants for the ADC-to-UART decimal reporter.
// Build option: ADC_UART_PARITY_EN adds an even-parity bit to every byte.
package adc_uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONV,
    ST_SEND
  } state_t;

  localparam logic [7:0] ASC_ZERO = 8'h30;
  localparam logic [7:0] ASC_CR   = 8'h0D;
  localparam logic [7:0] ASC_LF   = 8'h0A;

  localparam int BYTES_PER_FRAME = 6;
  localparam int CONV_CYCLES     = 10;

`ifdef ADC_UART_PARITY_EN
  localparam int BITS_PER_BYTE = 11;
`else
  localparam int BITS_PER_BYTE = 10;
`endif

  // One double-dabble iteration: add 3 to nibbles >= 5, then shift in bit_in.
  function automatic logic [15:0] dabble_step(input logic [15:0] bcd, input logic bit_in);
    logic [15:0] adj;
    for (int unsigned i = 0; i < 4; i++) begin
      adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    end
    return {adj[14:0], bit_in};
  endfunction

  function automatic logic [7:0] frame_byte(input logic [2:0] idx, input logic [15:0] bcd);
    case (idx)
      3'd0:    return ASC_ZERO + {4'h0, bcd[15:12]};
      3'd1:    return ASC_ZERO + {4'h0, bcd[11:8]};
      3'd2:    return ASC_ZERO + {4'h0, bcd[7:4]};
      3'd3:    return ASC_ZERO + {4'h0, bcd[3:0]};
      3'd4:    return ASC_CR;
      default: return ASC_LF;
    endcase
  endfunction

endpackage

// File: rtl/adc_uart_reporter_uart.sv
// Single-byte UART transmitter with registered TX; a load on the done cycle
// chains the next start bit directly after the stop bit.
module uart_tx_byte
  import adc_uart_pkg::*;
#(
  parameter int BAUD_DIV = 434
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_load,
  input  logic [7:0] i_data,
  output logic       o_tx,
  output logic       o_done
);

  localparam int             BW        = $clog2(BAUD_DIV);
  localparam logic [BW-1:0]  BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [3:0]     BIT_LAST  = 4'(BITS_PER_BYTE - 1);

  logic          r_active;
  logic [BW-1:0] r_baud;
  logic [3:0]    r_bit;
  logic [7:0]    r_data;
  logic          r_tx;

  logic          w_wrap;
  logic [3:0]    w_bit_nx;
  logic [2:0]    w_data_idx;
  logic          w_bit_val;

  assign w_wrap     = r_active && (r_baud == BAUD_LAST);
  assign w_bit_nx   = r_bit + 4'd1;
  assign w_data_idx = 3'(w_bit_nx - 4'd1);

  // Value of the bit that starts when the current one wraps (start bit is set on load).
  always_comb begin
    w_bit_val = 1'b1;
    if (w_bit_nx <= 4'd8) begin
      w_bit_val = r_data[w_data_idx];
    end
`ifdef ADC_UART_PARITY_EN
    else if (w_bit_nx == 4'd9) begin
      w_bit_val = ^r_data;
    end
`endif
  end

  assign o_done = w_wrap && (r_bit == BIT_LAST);
  assign o_tx   = r_tx;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_active <= 1'b0;
      r_baud   <= '0;
      r_bit    <= '0;
      r_data   <= '0;
      r_tx     <= 1'b1;
    end else if (i_load) begin
      r_active <= 1'b1;
      r_baud   <= '0;
      r_bit    <= '0;
      r_data   <= i_data;
      r_tx     <= 1'b0;
    end else if (r_active) begin
      if (w_wrap) begin
        r_baud <= '0;
        if (r_bit == BIT_LAST) begin
          r_active <= 1'b0;
          r_bit    <= '0;
          r_tx     <= 1'b1;
        end else begin
          r_bit <= w_bit_nx;
          r_tx  <= w_bit_val;
        end
      end else begin
        r_baud <= r_baud + BW'(1);
      end
    end
  end

endmodule

// File: rtl/adc_uart_reporter.sv
// Latches a 10-bit ADC sample, converts it to 4 BCD digits and sends "DDDD\r\n".
// Build option: ADC_UART_PARITY_EN (even parity per byte, see uart_tx_byte).
module adc_uart_reporter
  import adc_uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115_200
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic [9:0] Sample_In,
  input  logic       Sample_Valid,
  output logic       UART_TX,
  output logic       Busy,
  output logic       Frame_Done
);

  // Must come out at 2 or more for the UART counters to make sense.
  localparam int         BAUD_DIV  = CLK_FREQ / BAUD;
  localparam logic [2:0] LAST_BYTE = 3'(BYTES_PER_FRAME - 1);
  localparam logic [3:0] CONV_LAST = 4'(CONV_CYCLES - 1);

  state_t      r_state, w_state_nx;
  logic [9:0]  r_sample;
  logic [15:0] r_bcd;
  logic [3:0]  r_conv_cnt;
  logic [2:0]  r_byte_idx;
  logic        r_frame_done;

  logic [15:0] w_bcd_nx;
  logic        w_load;
  logic [7:0]  w_load_data;
  logic        w_byte_done;
  logic        w_frame_end;

  assign w_bcd_nx    = dabble_step(r_bcd, r_sample[9]);
  assign w_frame_end = (r_state == ST_SEND) && w_byte_done && (r_byte_idx == LAST_BYTE);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) r_state <= ST_IDLE;
    else       r_state <= w_state_nx;
  end

  // The first byte is loaded on the last CONV cycle from the final BCD value so
  // the start bit appears in the first SEND cycle.
  always_comb begin
    w_state_nx  = r_state;
    w_load      = 1'b0;
    w_load_data = '0;
    case (r_state)
      ST_IDLE: begin
        if (Sample_Valid) w_state_nx = ST_CONV;
      end
      ST_CONV: begin
        if (r_conv_cnt == CONV_LAST) begin
          w_state_nx  = ST_SEND;
          w_load      = 1'b1;
          w_load_data = frame_byte(3'd0, w_bcd_nx);
        end
      end
      ST_SEND: begin
        if (w_byte_done) begin
          if (r_byte_idx == LAST_BYTE) begin
            w_state_nx = ST_IDLE;
          end else begin
            w_load      = 1'b1;
            w_load_data = frame_byte(r_byte_idx + 3'd1, r_bcd);
          end
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_sample     <= '0;
      r_bcd        <= '0;
      r_conv_cnt   <= '0;
      r_byte_idx   <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_frame_end;
      case (r_state)
        ST_IDLE: begin
          if (Sample_Valid) begin
            r_sample   <= Sample_In;
            r_bcd      <= '0;
            r_conv_cnt <= '0;
          end
        end
        ST_CONV: begin
          r_bcd      <= w_bcd_nx;
          r_sample   <= {r_sample[8:0], 1'b0};
          r_conv_cnt <= r_conv_cnt + 4'd1;
          if (r_conv_cnt == CONV_LAST) r_byte_idx <= '0;
        end
        ST_SEND: begin
          if (w_byte_done && (r_byte_idx != LAST_BYTE)) r_byte_idx <= r_byte_idx + 3'd1;
        end
        default: ;
      endcase
    end
  end

  uart_tx_byte #(
    .BAUD_DIV(BAUD_DIV)
  ) u_tx (
    .i_clk  (CLK),
    .i_rst_n(RSTn),
    .i_load (w_load),
    .i_data (w_load_data),
    .o_tx   (UART_TX),
    .o_done (w_byte_done)
  );

  assign Busy       = (r_state != ST_IDLE);
  assign Frame_Done = r_frame_done;

endmodule
